// File: rtl/rns_ntt_sequencer_if.sv
// Job and engine handshake bundle for rns_ntt_sequencer.
//   slave  : sequencer view (takes jobs, drives the NTT engine).
//   master : environment view (job issuer plus engine).
// Job side   : job_valid/job_ready handshake, job_base, job_stride, job_limbs, job_mode.
// Engine side: eng_start/eng_done four-phase handshake, eng_mode, eng_addr, eng_q, eng_mu,
//              eng_n_inv.
interface rns_ntt_sequencer_if #(
    parameter int unsigned LIMB_LOG = 3
);
    logic              job_valid;
    logic              job_ready;
    logic [63:0]       job_base;
    logic [63:0]       job_stride;
    logic [LIMB_LOG:0] job_limbs;
    logic              job_mode;

    logic              eng_start;
    logic              eng_done;
    logic              eng_mode;
    logic [63:0]       eng_addr;
    logic [63:0]       eng_q;
    logic [63:0]       eng_mu;
    logic [63:0]       eng_n_inv;

    modport slave (
        input  job_valid, job_base, job_stride, job_limbs, job_mode, eng_done,
        output job_ready, eng_start, eng_mode, eng_addr, eng_q, eng_mu, eng_n_inv
    );

    modport master (
        output job_valid, job_base, job_stride, job_limbs, job_mode, eng_done,
        input  job_ready, eng_start, eng_mode, eng_addr, eng_q, eng_mu, eng_n_inv
    );
endinterface

// File: rtl/rns_ntt_sequencer.sv
// RNS NTT limb sequencer: walks the limbs of one job, handing the NTT engine the DMA address
// and the per-limb modulus constants, one four-phase start/done transaction per limb.
// Optional build macro NTT_SEQ_TIMEOUT_EN adds a watchdog that aborts a stalled job and sets err.
// Ports:
//   clk, rst_n                       : clock, asynchronous active-low reset
//   tbl_we, tbl_idx, tbl_q, tbl_mu,
//   tbl_n_inv                        : parameter-table write port (not cleared by reset)
//   bus (rns_ntt_sequencer_if.slave) : job handshake and engine handshake
//   busy, limb_idx, job_done, err    : status; job_done is a one-cycle pulse
module rns_ntt_sequencer #(
    parameter int unsigned MAX_LIMBS = 8,
    parameter int unsigned LIMB_LOG  = 3,
    parameter int unsigned TIMEOUT   = 65536
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  tbl_we,
    input  logic [LIMB_LOG-1:0]   tbl_idx,
    input  logic [63:0]           tbl_q,
    input  logic [63:0]           tbl_mu,
    input  logic [63:0]           tbl_n_inv,
    rns_ntt_sequencer_if.slave    bus,
    output logic                  busy,
    output logic [LIMB_LOG-1:0]   limb_idx,
    output logic                  job_done,
    output logic                  err
);
    typedef enum logic [1:0] {StIdle, StIssue, StRelease} state_e;

    localparam logic [LIMB_LOG:0] MaxLimbsW = MAX_LIMBS[LIMB_LOG:0];

    state_e            state_q;
    logic [LIMB_LOG:0] limbs_q;
    logic [63:0]       stride_q;

    logic [63:0] q_tbl   [MAX_LIMBS];
    logic [63:0] mu_tbl  [MAX_LIMBS];
    logic [63:0] ninv_tbl[MAX_LIMBS];

    logic [LIMB_LOG:0]   job_limbs_sat;
    logic [LIMB_LOG-1:0] next_idx;
    logic                last_limb;

    assign job_limbs_sat = (bus.job_limbs > MaxLimbsW) ? MaxLimbsW : bus.job_limbs;
    assign next_idx      = limb_idx + LIMB_LOG'(1);
    assign last_limb     = ({1'b0, limb_idx} == (limbs_q - (LIMB_LOG+1)'(1)));
    assign busy          = (state_q != StIdle);
    assign bus.job_ready = (state_q == StIdle);

    // No reset: table contents survive rst_n. Loads read the pre-edge value, so a write on
    // the load edge only shows up on later loads.
    always_ff @(posedge clk) begin
        if (tbl_we) begin
            q_tbl[tbl_idx]    <= tbl_q;
            mu_tbl[tbl_idx]   <= tbl_mu;
            ninv_tbl[tbl_idx] <= tbl_n_inv;
        end
    end

`ifdef NTT_SEQ_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT + 1);
    logic [CntW-1:0] cnt_q;
    logic            timeout_hit;
    // Fires on the edge at which the state has been held for TIMEOUT cycles.
    assign timeout_hit = (cnt_q == CntW'(TIMEOUT - 1));
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            limbs_q       <= '0;
            stride_q      <= '0;
            limb_idx      <= '0;
            job_done      <= 1'b0;
            bus.eng_start <= 1'b0;
            bus.eng_mode  <= 1'b0;
            bus.eng_addr  <= '0;
            bus.eng_q     <= '0;
            bus.eng_mu    <= '0;
            bus.eng_n_inv <= '0;
`ifdef NTT_SEQ_TIMEOUT_EN
            cnt_q         <= '0;
            err           <= 1'b0;
`endif
        end else begin
            job_done <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (bus.job_valid) begin
                        stride_q     <= bus.job_stride;
                        limbs_q      <= job_limbs_sat;
                        limb_idx     <= '0;
                        bus.eng_mode <= bus.job_mode;
                        bus.eng_addr <= bus.job_base;
`ifdef NTT_SEQ_TIMEOUT_EN
                        err          <= 1'b0;
                        cnt_q        <= '0;
`endif
                        if (job_limbs_sat == '0) begin
                            // Empty job completes without touching the engine.
                            job_done <= 1'b1;
                        end else begin
                            bus.eng_start <= 1'b1;
                            bus.eng_q     <= q_tbl[0];
                            bus.eng_mu    <= mu_tbl[0];
                            bus.eng_n_inv <= ninv_tbl[0];
                            state_q       <= StIssue;
                        end
                    end
                end
                StIssue: begin
                    if (bus.eng_done) begin
                        bus.eng_start <= 1'b0;
                        state_q       <= StRelease;
`ifdef NTT_SEQ_TIMEOUT_EN
                        cnt_q         <= '0;
                    end else if (timeout_hit) begin
                        bus.eng_start <= 1'b0;
                        state_q       <= StIdle;
                        job_done      <= 1'b1;
                        err           <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
`endif
                    end
                end
                StRelease: begin
                    if (!bus.eng_done) begin
                        if (last_limb) begin
                            state_q  <= StIdle;
                            job_done <= 1'b1;
                        end else begin
                            limb_idx      <= next_idx;
                            bus.eng_addr  <= bus.eng_addr + stride_q;
                            bus.eng_q     <= q_tbl[next_idx];
                            bus.eng_mu    <= mu_tbl[next_idx];
                            bus.eng_n_inv <= ninv_tbl[next_idx];
                            bus.eng_start <= 1'b1;
                            state_q       <= StIssue;
`ifdef NTT_SEQ_TIMEOUT_EN
                            cnt_q         <= '0;
`endif
                        end
`ifdef NTT_SEQ_TIMEOUT_EN
                    end else if (timeout_hit) begin
                        state_q  <= StIdle;
                        job_done <= 1'b1;
                        err      <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
`endif
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_rns_ntt_sequencer.sv
// Directed bench for rns_ntt_sequencer with a behavioural engine (done 5 cycles after start,
// dropped one cycle after start falls) and a monitor logging every engine transaction.
module tb_rns_ntt_sequencer;
    localparam int unsigned MaxLimbs = 8;
    localparam int unsigned LimbLog  = 3;
    localparam int unsigned Timeout  = 16;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               tbl_we = 1'b0;
    logic [LimbLog-1:0] tbl_idx = '0;
    logic [63:0]        tbl_q = '0;
    logic [63:0]        tbl_mu = '0;
    logic [63:0]        tbl_n_inv = '0;
    logic               busy;
    logic [LimbLog-1:0] limb_idx;
    logic               job_done;
    logic               err;

    rns_ntt_sequencer_if #(.LIMB_LOG(LimbLog)) bus ();

    rns_ntt_sequencer #(
        .MAX_LIMBS(MaxLimbs),
        .LIMB_LOG (LimbLog),
        .TIMEOUT  (Timeout)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tbl_we   (tbl_we),
        .tbl_idx  (tbl_idx),
        .tbl_q    (tbl_q),
        .tbl_mu   (tbl_mu),
        .tbl_n_inv(tbl_n_inv),
        .bus      (bus),
        .busy     (busy),
        .limb_idx (limb_idx),
        .job_done (job_done),
        .err      (err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // Engine model
    bit eng_en  = 1'b1;
    int eng_cnt = 0;
    initial begin
        bus.eng_done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!eng_en || !bus.eng_start) begin
                eng_cnt      = 0;
                bus.eng_done = 1'b0;
            end else if (!bus.eng_done) begin
                eng_cnt++;
                if (eng_cnt == 5) bus.eng_done = 1'b1;
            end
        end
    end

    // Transaction monitor
    logic [63:0] st_addr[$];
    logic [63:0] st_q[$];
    logic [63:0] st_mu[$];
    logic        st_mode[$];
    int          st_idx[$];
    int          jd_cnt = 0;
    int          jd_long = 0;
    int          hold_err = 0;
    int          start_cycles = 0;
    initial begin
        logic        p_start = 1'b0;
        logic        p_jd = 1'b0;
        logic [63:0] p_addr = '0;
        logic [63:0] p_q = '0;
        logic        p_mode = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.eng_start) start_cycles++;
            if (bus.eng_start && !p_start) begin
                st_addr.push_back(bus.eng_addr);
                st_q.push_back(bus.eng_q);
                st_mu.push_back(bus.eng_mu);
                st_mode.push_back(bus.eng_mode);
                st_idx.push_back(int'(limb_idx));
            end
            if (bus.eng_start && p_start &&
                (bus.eng_addr != p_addr || bus.eng_q != p_q || bus.eng_mode != p_mode))
                hold_err++;
            if (job_done) jd_cnt++;
            if (job_done && p_jd) jd_long++;
            p_start = bus.eng_start;
            p_jd    = job_done;
            p_addr  = bus.eng_addr;
            p_q     = bus.eng_q;
            p_mode  = bus.eng_mode;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic clear_log();
        st_addr.delete();
        st_q.delete();
        st_mu.delete();
        st_mode.delete();
        st_idx.delete();
    endtask

    task automatic write_tbl(input int idx, input logic [63:0] q, input logic [63:0] mu,
                             input logic [63:0] ninv);
        @(negedge clk);
        tbl_we    = 1'b1;
        tbl_idx   = LimbLog'(idx);
        tbl_q     = q;
        tbl_mu    = mu;
        tbl_n_inv = ninv;
        @(negedge clk);
        tbl_we = 1'b0;
    endtask

    // Returns at the negedge following the acceptance edge.
    task automatic start_job(input logic [63:0] base, input logic [63:0] stride,
                             input int limbs, input logic mode);
        int n = 0;
        @(negedge clk);
        while (!bus.job_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        bus.job_valid  = 1'b1;
        bus.job_base   = base;
        bus.job_stride = stride;
        bus.job_limbs  = (LimbLog+1)'(limbs);
        bus.job_mode   = mode;
        @(negedge clk);
        bus.job_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int base = jd_cnt;
        int n = 0;
        while (jd_cnt == base && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, 64'(jd_cnt != base), 64'd1);
    endtask

    initial begin
        int jd0;
        int sc0;
        bus.job_valid  = 1'b0;
        bus.job_base   = '0;
        bus.job_stride = '0;
        bus.job_limbs  = '0;
        bus.job_mode   = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check_eq("rst_eng_start", 64'(bus.eng_start), 64'd0);
        check_eq("rst_eng_addr", bus.eng_addr, 64'd0);
        check_eq("rst_eng_q", bus.eng_q, 64'd0);
        check_eq("rst_eng_mode", 64'(bus.eng_mode), 64'd0);
        check_eq("rst_limb_idx", 64'(limb_idx), 64'd0);
        check_eq("rst_job_done", 64'(job_done), 64'd0);
        check_eq("rst_err", 64'(err), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst_job_ready", 64'(bus.job_ready), 64'd1);

        for (int i = 0; i < int'(MaxLimbs); i++)
            write_tbl(i, 64'h7FFF_F001 + 64'(i), 64'h100 + 64'(i), 64'h200 + 64'(i));

        // Three-limb INTT job
        clear_log();
        jd0 = jd_cnt;
        start_job(64'h1000, 64'h8000, 3, 1'b1);
        wait_done("a_done", 200);
        repeat (5) @(negedge clk);
        check_eq("a_starts", 64'(st_addr.size()), 64'd3);
        if (st_addr.size() == 3) begin
            check_eq("a_addr0", st_addr[0], 64'h1000);
            check_eq("a_addr1", st_addr[1], 64'h9000);
            check_eq("a_addr2", st_addr[2], 64'h11000);
            for (int i = 0; i < 3; i++) begin
                check_eq($sformatf("a_q%0d", i), st_q[i], 64'h7FFF_F001 + 64'(i));
                check_eq($sformatf("a_mu%0d", i), st_mu[i], 64'h100 + 64'(i));
                check_eq($sformatf("a_mode%0d", i), 64'(st_mode[i]), 64'd1);
                check_eq($sformatf("a_idx%0d", i), 64'(st_idx[i]), 64'(i));
            end
        end
        check_eq("a_job_done_cnt", 64'(jd_cnt - jd0), 64'd1);
        check_eq("a_busy_after", 64'(busy), 64'd0);

        // Zero-limb job
        clear_log();
        jd0 = jd_cnt;
        @(negedge clk);
        bus.job_valid = 1'b1;
        bus.job_limbs = '0;
        @(negedge clk);
        bus.job_valid = 1'b0;
        check_eq("z_job_done", 64'(job_done), 64'd1);
        check_eq("z_busy", 64'(busy), 64'd0);
        @(negedge clk);
        check_eq("z_job_done_fall", 64'(job_done), 64'd0);
        check_eq("z_busy2", 64'(busy), 64'd0);
        check_eq("z_no_start", 64'(st_addr.size()), 64'd0);
        check_eq("z_done_cnt", 64'(jd_cnt - jd0), 64'd1);

        // Limb count saturation
        clear_log();
        start_job(64'h0, 64'h40, 15, 1'b0);
        wait_done("s_done", 400);
        check_eq("s_starts", 64'(st_addr.size()), 64'd8);
        if (st_addr.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                check_eq($sformatf("s_idx%0d", i), 64'(st_idx[i]), 64'(i));
                check_eq($sformatf("s_addr%0d", i), st_addr[i], 64'h40 * 64'(i));
            end
            check_eq("s_q7", st_q[7], 64'h7FFF_F008);
            check_eq("s_mode", 64'(st_mode[7]), 64'd0);
        end

        // Address wrap-around
        clear_log();
        start_job(64'hFFFF_FFFF_FFFF_F000, 64'h2000, 2, 1'b0);
        wait_done("w_done", 200);
        check_eq("w_starts", 64'(st_addr.size()), 64'd2);
        if (st_addr.size() == 2) check_eq("w_addr1", st_addr[1], 64'h1000);

        // Table write on the limb-1 load edge
        clear_log();
        fork
            begin
                start_job(64'h0, 64'h100, 2, 1'b0);
                wait_done("t_done", 200);
            end
            begin
                int n = 0;
                @(negedge clk);
                while (!(busy && !bus.eng_start && !bus.eng_done && limb_idx == '0) && n < 200)
                begin
                    @(negedge clk);
                    n++;
                end
                check_eq("t_release_seen", 64'(n < 200), 64'd1);
                tbl_we    = 1'b1;
                tbl_idx   = LimbLog'(1);
                tbl_q     = 64'hDEAD_BEEF;
                tbl_mu    = 64'h111;
                tbl_n_inv = 64'h222;
                @(negedge clk);
                tbl_we = 1'b0;
            end
        join
        check_eq("t_starts", 64'(st_q.size()), 64'd2);
        if (st_q.size() == 2) check_eq("t_q1_old", st_q[1], 64'h7FFF_F002);
        clear_log();
        start_job(64'h0, 64'h100, 2, 1'b0);
        wait_done("t2_done", 200);
        if (st_q.size() == 2) check_eq("t_q1_new", st_q[1], 64'hDEAD_BEEF);
        else check_eq("t2_starts", 64'(st_q.size()), 64'd2);

        // Reset mid-job
        clear_log();
        jd0 = jd_cnt;
        start_job(64'h5000, 64'h10, 3, 1'b1);
        repeat (3) @(negedge clk);
        check_eq("r_started", 64'(bus.eng_start), 64'd1);
        rst_n = 1'b0;
        #1;
        check_eq("r_eng_start", 64'(bus.eng_start), 64'd0);
        check_eq("r_eng_addr", bus.eng_addr, 64'd0);
        check_eq("r_eng_q", bus.eng_q, 64'd0);
        check_eq("r_eng_mu", bus.eng_mu, 64'd0);
        check_eq("r_eng_n_inv", bus.eng_n_inv, 64'd0);
        check_eq("r_eng_mode", 64'(bus.eng_mode), 64'd0);
        check_eq("r_limb_idx", 64'(limb_idx), 64'd0);
        check_eq("r_busy", 64'(busy), 64'd0);
        check_eq("r_job_done", 64'(job_done), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check_eq("r_no_job_done", 64'(jd_cnt - jd0), 64'd0);
        check_eq("r_one_start", 64'(st_addr.size()), 64'd1);
        check_eq("r_ready", 64'(bus.job_ready), 64'd1);

`ifdef NTT_SEQ_TIMEOUT_EN
        // Stalled engine trips the watchdog
        clear_log();
        eng_en = 1'b0;
        sc0 = start_cycles;
        start_job(64'h0, 64'h8, 4, 1'b0);
        wait_done("to_done", 100);
        check_eq("to_start_cycles", 64'(start_cycles - sc0), 64'd16);
        check_eq("to_err", 64'(err), 64'd1);
        check_eq("to_busy", 64'(busy), 64'd0);
        check_eq("to_starts", 64'(st_addr.size()), 64'd1);
        eng_en = 1'b1;
        start_job(64'h0, 64'h8, 1, 1'b0);
        check_eq("to_err_clear", 64'(err), 64'd0);
        wait_done("to2_done", 100);
`else
        sc0 = start_cycles;
        check_eq("err_tied", 64'(err), 64'd0);
        check_eq("start_cycles_seen", 64'(sc0 > 0), 64'd1);
`endif
        check_eq("hold_stable", 64'(hold_err), 64'd0);
        check_eq("job_done_width", 64'(jd_long), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/rns_ntt_sequencer.md
RNS_NTT_SEQUENCER -- requirements
Module: rns_ntt_sequencer

Interface
REQ-001 SHALL have parameter MAX_LIMBS, default 8, meaning the number of RNS parameter-table entries (power of two).
REQ-002 SHALL have parameter LIMB_LOG, default 3, meaning log2(MAX_LIMBS).
REQ-003 SHALL have parameter TIMEOUT, default 65536, meaning the watchdog limit in cycles (used only under REQ-027).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is clocked on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have parameter-table write ports: tbl_we in 1; tbl_idx in LIMB_LOG; tbl_q, tbl_mu, tbl_n_inv in 64 each (modulus, Barrett constant, N^-1 mod q).
REQ-007 SHALL have job ports: job_valid in 1; job_ready out 1; job_base in 64 (DMA address of limb 0); job_stride in 64 (address step per limb); job_limbs in LIMB_LOG+1; job_mode in 1 (0=NTT, 1=INTT).
REQ-008 SHALL have engine ports: eng_start out 1; eng_done in 1; eng_mode out 1; eng_addr out 64; eng_q, eng_mu, eng_n_inv out 64 each.
REQ-009 SHALL have status ports: busy out 1; limb_idx out LIMB_LOG; job_done out 1 (one-cycle pulse); err out 1.

Function
REQ-010 SHALL implement states IDLE, ISSUE, RELEASE.
REQ-011 SHALL drive job_ready=1 only in IDLE; busy = (state != IDLE).
REQ-012 SHALL accept a job on a rising edge with job_valid && job_ready, and SHALL latch base, stride, mode and limb count at that edge.
REQ-013 SHALL saturate a job_limbs value above MAX_LIMBS to MAX_LIMBS.
REQ-014 SHALL handle job_limbs=0 by staying in IDLE and pulsing job_done on the cycle after acceptance, with no eng_start.
REQ-015 SHALL, on accepting a job with limbs>=1, enter ISSUE on the next cycle with: eng_start=1, limb_idx=0, eng_addr=job_base, eng_mode=job_mode, and eng_q/eng_mu/eng_n_inv = table[0].
REQ-016 SHALL hold eng_start and all eng_* outputs constant while in ISSUE; these outputs are registered.
REQ-017 SHALL, in ISSUE, when eng_done=1 is sampled, clear eng_start and enter RELEASE on the next cycle.
REQ-018 SHALL, in RELEASE, wait for eng_done=0 (four-phase handshake), then branch as in REQ-019 and REQ-020.
REQ-019 On the last limb (limb_idx == limbs-1), SHALL return to IDLE and pulse job_done for exactly 1 cycle.
REQ-020 Otherwise, SHALL do the following in one edge: limb_idx+1; eng_addr += stride (modulo 2^64, wrap-around silent); load table[limb_idx+1]; eng_start=1; enter ISSUE.
REQ-021 SHALL take table entries from the table contents at the load edge; a tbl_we to the same index on that edge SHALL NOT affect the loaded value (old data).
REQ-022 SHALL accept table writes in any state; writes affect only later loads.
REQ-023 SHALL ignore eng_done in IDLE; job_valid while busy SHALL NOT be accepted.

Reset
REQ-024 On rst_n=0, SHALL immediately (asynchronously) set: state=IDLE; eng_start=0; eng_mode=0; eng_addr=0; eng_q/eng_mu/eng_n_inv=0; limb_idx=0; job_done=0; err=0; job_ready=1 after reset release.
REQ-025 Reset SHALL NOT clear the parameter table contents (undefined after power-up until written).
REQ-026 Reset mid-job SHALL abort the job with no job_done pulse.

Configuration
REQ-027 Macro NTT_SEQ_TIMEOUT_EN: when defined, SHALL include a cycle counter, cleared on every entry to ISSUE or RELEASE.
REQ-028 With NTT_SEQ_TIMEOUT_EN defined, if the counter reaches TIMEOUT in ISSUE or RELEASE, SHALL: clear eng_start; abort remaining limbs; go to IDLE; pulse job_done; set err=1, sticky until the next job acceptance.
REQ-029 Without NTT_SEQ_TIMEOUT_EN, SHALL have no counter logic, tie err to 0, and wait indefinitely.

Verification
REQ-030 Table[0..2] written with q=0x7FFF_F001+i; job base=0x1000, stride=0x8000, limbs=3, mode=1; engine model asserts done 5 cycles after start and drops it 1 cycle after start falls -> three starts with eng_addr 0x1000, 0x9000, 0x11000, eng_q matching table[i], eng_mode=1, one job_done after the third release.
REQ-031 Job limbs=0 -> job_done pulses 1 cycle after acceptance, eng_start never asserted, busy stays 0.
REQ-032 Job limbs=15 with MAX_LIMBS=8 -> exactly 8 engine transactions; limb_idx runs 0..7.
REQ-033 Job base=0xFFFF_FFFF_FFFF_F000, stride=0x2000, limbs=2 -> second eng_addr=0x1000.
REQ-034 tbl_we to index 1 on the same edge as the limb-1 load -> eng_q carries the old value.
REQ-035 NTT_SEQ_TIMEOUT_EN defined, TIMEOUT=16, engine never raises done -> eng_start falls after 16 cycles, job_done pulses, err=1; rst_n pulsed mid-job without the macro -> all outputs 0 and no job_done.
